// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with a skid slot. o_ready depends only on held state,
// so downstream backpressure never reaches upstream combinationally.
module pipe_skid_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {StEmpty, StMain, StSkid} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  accept, consume;

  assign o_valid = (state_q != StEmpty);
  assign o_ready = (state_q != StSkid);
  assign o_data  = main_q;

  assign accept  = i_valid & o_ready;
  assign consume = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = i_data;
          state_d = StMain;
        end
      end
      StMain: begin
        if (accept && consume) begin
          main_d = i_data;
        end else if (accept) begin
          skid_d  = i_data;
          state_d = StSkid;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (consume) begin
          main_d  = skid_q;
          state_d = StMain;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush only drops occupancy; a same-cycle consume has already happened downstream.
    if (i_flush) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
